// File: rtl/dlsc_pcie_s6_rdtag.sv
// Read-request tag allocator and completion-credit governor.
// Hands out the lowest free PCIe tag to each split read command, reserves
// completion-buffer space (DW) for it, and returns tag and space as the
// completion path reports data for that tag.

// Per-tag bookkeeping: in-use flag and DW still expected for the tag.
module dlsc_pcie_s6_rdtag_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alloc,
  input  logic [10:0] alloc_dw,
  input  logic        hit,
  input  logic [10:0] hit_len,
  input  logic        hit_last,
  output logic        used,
  output logic [10:0] rem
);

  // Allocation loads the full request size; legal completions drain it.
  // A final completion frees the tag, discarding any leftover count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used <= 1'b0;
      rem  <= '0;
    end else if (alloc) begin
      used <= 1'b1;
      rem  <= alloc_dw;
    end else if (hit) begin
      if (hit_last) begin
        used <= 1'b0;
        rem  <= '0;
      end else begin
        rem  <= rem - hit_len;
      end
    end
  end

endmodule

module dlsc_pcie_s6_rdtag #(
  parameter int ADDR     = 32,
  parameter int LEN      = 10,
  parameter int META     = 1,
  parameter int TAGS     = 8,
  parameter int TAG_BITS = 5,
  parameter int CPL_DW   = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                cmd_ready,
  input  logic                cmd_valid,
  input  logic [ADDR-3:0]     cmd_addr,
  input  logic [LEN-1:0]      cmd_len,
  input  logic [META-1:0]     cmd_meta,
  input  logic                cmd_last,
  input  logic                req_ready,
  output logic                req_valid,
  output logic [ADDR-3:0]     req_addr,
  output logic [LEN-1:0]      req_len,
  output logic [TAG_BITS-1:0] req_tag,
  output logic [META-1:0]     req_meta,
  output logic                req_last,
  input  logic                cpl_valid,
  input  logic [TAG_BITS-1:0] cpl_tag,
  input  logic [10:0]         cpl_len,
  input  logic                cpl_last,
  output logic                cpl_err,
  output logic [TAG_BITS:0]   outstanding,
  output logic                idle
);

  // Wide enough for the largest buffer (4096 DW).
  localparam int CW = 13;

  logic [TAGS-1:0]         used;
  logic [TAGS-1:0][10:0]   rem;
  logic [TAGS-1:0]         alloc_vec;
  logic [TAGS-1:0]         hit_vec;
  logic [CW-1:0]           credits, credits_nxt;
  logic [TAG_BITS:0]       outstanding_nxt;
  logic [TAG_BITS-1:0]     sel;
  logic                    any_free;
  logic                    cur_used;
  logic [10:0]             cur_rem;
  logic [10:0]             dw;
  logic [10:0]             ret;
  logic                    cpl_ok;
  logic                    accept;

  // Allocation, completion legality and credit arithmetic; the allocator
  // only looks at registered state, so a tag freed this cycle is not reused.
  always_comb begin
    dw       = (cmd_len == '0) ? 11'd1024 : 11'(cmd_len);
    sel      = '0;
    any_free = 1'b0;
    for (int i = TAGS-1; i >= 0; i--) begin
      if (!used[i]) begin
        sel      = TAG_BITS'(i);
        any_free = 1'b1;
      end
    end
    // Tags at or above TAGS never match, so they read as not in use.
    cur_used = 1'b0;
    cur_rem  = '0;
    for (int i = 0; i < TAGS; i++) begin
      if (cpl_tag == TAG_BITS'(i)) begin
        cur_used = used[i];
        cur_rem  = rem[i];
      end
    end
    cpl_ok    = cpl_valid && cur_used && (cpl_len <= cur_rem);
    // A final completion returns everything still reserved for the tag.
    ret       = cpl_last ? cur_rem : cpl_len;
    cmd_ready = (!req_valid || req_ready) && any_free && (credits >= CW'(dw));
    accept    = cmd_valid && cmd_ready;
    credits_nxt = credits - (accept ? CW'(dw) : CW'(0)) + (cpl_ok ? CW'(ret) : CW'(0));
    outstanding_nxt = outstanding + (TAG_BITS+1)'(accept) - (TAG_BITS+1)'(cpl_ok && cpl_last);
    for (int i = 0; i < TAGS; i++) begin
      alloc_vec[i] = accept && (sel == TAG_BITS'(i));
      hit_vec[i]   = cpl_ok && (cpl_tag == TAG_BITS'(i));
    end
  end

  for (genvar g = 0; g < TAGS; g++) begin : g_slot
    dlsc_pcie_s6_rdtag_slot u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .alloc    (alloc_vec[g]),
      .alloc_dw (dw),
      .hit      (hit_vec[g]),
      .hit_len  (cpl_len),
      .hit_last (cpl_last),
      .used     (used[g]),
      .rem      (rem[g])
    );
  end

  // Credit pool, tag population count and illegal-report pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits     <= CW'(CPL_DW);
      outstanding <= '0;
      cpl_err     <= 1'b0;
    end else begin
      credits     <= credits_nxt;
      outstanding <= outstanding_nxt;
      cpl_err     <= cpl_valid && !cpl_ok;
    end
  end

  // Request output register: loads on accept, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_len   <= '0;
      req_tag   <= '0;
      req_meta  <= '0;
      req_last  <= 1'b0;
    end else if (accept) begin
      req_valid <= 1'b1;
      req_addr  <= cmd_addr;
      req_len   <= cmd_len;
      req_tag   <= sel;
      req_meta  <= cmd_meta;
      req_last  <= cmd_last;
    end else if (req_ready) begin
      req_valid <= 1'b0;
    end
  end

  assign idle = (outstanding == '0) && !req_valid;

endmodule

// File: tb/tb_dlsc_pcie_s6_rdtag.sv
// Directed bench for the read tag allocator: expected requests and error
// pulses go into queues, a negedge monitor pops and compares them.
module tb_dlsc_pcie_s6_rdtag;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_ready, cmd_valid;
  logic [29:0] cmd_addr;
  logic [9:0]  cmd_len;
  logic [0:0]  cmd_meta;
  logic        cmd_last;
  logic        req_ready, req_valid;
  logic [29:0] req_addr;
  logic [9:0]  req_len;
  logic [4:0]  req_tag;
  logic [0:0]  req_meta;
  logic        req_last;
  logic        cpl_valid;
  logic [4:0]  cpl_tag;
  logic [10:0] cpl_len;
  logic        cpl_last;
  logic        cpl_err;
  logic [5:0]  outstanding;
  logic        idle;

  typedef struct packed {
    logic [29:0] addr;
    logic [9:0]  len;
    logic [4:0]  tag;
    logic        meta;
    logic        last;
  } req_t;

  req_t req_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  dlsc_pcie_s6_rdtag dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_meta(cmd_meta), .cmd_last(cmd_last),
    .req_ready(req_ready), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_tag(req_tag), .req_meta(req_meta), .req_last(req_last),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_len(cpl_len), .cpl_last(cpl_last),
    .cpl_err(cpl_err), .outstanding(outstanding), .idle(idle)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every transferred request and every error pulse must match
  // the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        if (req_q.size() == 0) check("req_q_nonempty", req_q.size(), 1);
        else begin
          req_t e;
          e = req_q.pop_front();
          check("req", {req_addr, req_len, req_tag, req_meta, req_last}, e);
        end
      end
      if (cpl_err) begin
        if (err_q.size() == 0) check("err_q_nonempty", err_q.size(), 1);
        else check("cpl_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  // Present a command and wait (bounded) for it to be accepted.
  task automatic issue(input logic [29:0] a, input logic [9:0] l, input logic m,
                       input logic lst, input logic [4:0] tag);
    int n = 0;
    cmd_addr = a; cmd_len = l; cmd_meta = m; cmd_last = lst; cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        check("issue_timeout", n, 0);
        cmd_valid = 1'b0;
        return;
      end
    end
    req_q.push_back('{addr: a, len: l, tag: tag, meta: m, last: lst});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // One-cycle completion report; illegal ones expect a pulse next edge.
  task automatic cpl(input logic [4:0] t, input logic [10:0] l, input logic lst, input bit err);
    cpl_tag = t; cpl_len = l; cpl_last = lst; cpl_valid = 1'b1;
    if (err) err_q.push_back(cyc + 1);
    @(posedge clk); #1;
    cpl_valid = 1'b0;
  endtask

  // Observe available credits through cmd_ready for a given length.
  task automatic probe(input string name, input logic [9:0] l, input logic exp);
    cmd_len = l;
    #1;
    check(name, cmd_ready, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_meta = '0;
    cmd_last = 1'b0; req_ready = 1'b0; cpl_valid = 1'b0; cpl_tag = '0;
    cpl_len = '0; cpl_last = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_req_valid", req_valid, 0);
    check("rst_idle", idle, 1);
    check("rst_outstanding", outstanding, 0);
    check("rst_cpl_err", cpl_err, 0);
    check("rst_req_fields", {req_addr, req_len, req_tag, req_meta, req_last}, 0);
    check("rst_cmd_ready_1024", cmd_ready, 1);
    rst_n = 1'b1; req_ready = 1'b1;
    @(posedge clk); #1;

    // Single command and its completion.
    issue(30'h100, 10'd32, 1'b1, 1'b1, 5'd0);
    check("single_outstanding", outstanding, 1);
    check("single_idle", idle, 0);
    probe("single_cred_1024", 10'd0, 1'b0);
    probe("single_cred_992", 10'd992, 1'b1);
    cpl(5'd0, 11'd32, 1'b1, 1'b0);
    check("single_done_outstanding", outstanding, 0);
    check("single_done_idle", idle, 1);
    probe("single_cred_back", 10'd0, 1'b1);

    // Tag exhaustion, then a freed tag is reused the following cycle.
    for (int i = 0; i < 8; i++) issue(30'h1000 + 30'(i), 10'd16, i[0], 1'b0, 5'(i));
    check("exh_outstanding", outstanding, 8);
    probe("exh_no_tag", 10'd16, 1'b0);
    fork
      issue(30'h2000, 10'd16, 1'b1, 1'b1, 5'd3);
      cpl(5'd3, 11'd16, 1'b1, 1'b0);
    join
    check("exh_refill_outstanding", outstanding, 8);
    for (int i = 0; i < 8; i++) cpl(5'(i), 11'd16, 1'b1, 1'b0);
    check("exh_drain_outstanding", outstanding, 0);
    probe("exh_cred_back", 10'd0, 1'b1);

    // Credit block on a full-buffer request.
    issue(30'h3000, 10'd0, 1'b0, 1'b1, 5'd0);
    probe("cred_block", 10'd1, 1'b0);
    fork
      issue(30'h3100, 10'd1, 1'b1, 1'b0, 5'd1);
      cpl(5'd0, 11'd512, 1'b0, 1'b0);
    join
    probe("cred_511_fit", 10'd511, 1'b1);
    probe("cred_512_block", 10'd512, 1'b0);
    cpl(5'd0, 11'd512, 1'b1, 1'b0);
    cpl(5'd1, 11'd1, 1'b1, 1'b0);
    probe("cred_restore", 10'd0, 1'b1);

    // Accept and completion in the same cycle.
    issue(30'h4000, 10'd896, 1'b0, 1'b0, 5'd0);
    issue(30'h4100, 10'd64, 1'b1, 1'b1, 5'd1);
    fork
      issue(30'h4200, 10'd64, 1'b0, 1'b1, 5'd2);
      cpl(5'd1, 11'd64, 1'b1, 1'b0);
    join
    probe("sim_cred_64", 10'd64, 1'b1);
    probe("sim_cred_65", 10'd65, 1'b0);
    check("sim_outstanding", outstanding, 2);
    issue(30'h4300, 10'd1, 1'b1, 1'b0, 5'd1);
    cpl(5'd0, 11'd896, 1'b1, 1'b0);
    cpl(5'd2, 11'd64, 1'b1, 1'b0);
    cpl(5'd1, 11'd1, 1'b1, 1'b0);
    probe("sim_cred_restore", 10'd0, 1'b1);

    // Illegal completion reports.
    cpl(5'd5, 11'd1, 1'b1, 1'b1);
    issue(30'h5000, 10'd32, 1'b0, 1'b1, 5'd0);
    cpl(5'd0, 11'd40, 1'b0, 1'b1);
    cpl(5'd9, 11'd1, 1'b1, 1'b1);
    check("err_outstanding", outstanding, 1);
    probe("err_cred_992", 10'd992, 1'b1);
    probe("err_cred_993", 10'd993, 1'b0);
    cpl(5'd0, 11'd32, 1'b1, 1'b0);
    check("err_done_outstanding", outstanding, 0);

    // Backpressure hold, then reset in the middle of it.
    req_ready = 1'b0;
    issue(30'h2A5, 10'd7, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", req_valid, 1);
      check("hold_fields", {req_addr, req_len, req_tag}, {30'h2A5, 10'd7, 5'd0});
      check("hold_cmd_ready", cmd_ready, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_valid", req_valid, 0);
    check("rst_mid_outstanding", outstanding, 0);
    req_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; req_ready = 1'b1;
    probe("rst_mid_cred", 10'd0, 1'b1);
    check("rst_mid_idle", idle, 1);
    cpl(5'd0, 11'd7, 1'b1, 1'b1);

    repeat (3) @(posedge clk); #1;
    check("req_q_drained", req_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dlsc_pcie_s6_rdtag.md
Name: dlsc_pcie_s6_rdtag

Overview:
- Read-request tag allocator and completion-credit governor. Sits directly downstream of the command splitter in the Spartan-6 PCIe master read path.
- Accepts split read commands (each no larger than Max_Read_Request_Size), assigns a free PCIe tag, and reserves completion-buffer space in DW.
- Emits a tagged request to the TLP formatter.
- Returns tags and credits as the completion path reports received data, so outstanding completions can never overrun the completion buffer.

Parameters:
- ADDR, 32, MSB+1 of DW address (LSB is always 2).
- LEN, 10, command/request length width in DW. 0 encodes 1024 DW.
- META, 1, metadata width, passed through unmodified.
- TAGS, 8, number of tags in the pool (1..32).
- TAG_BITS, 5, width of tag ports. Must satisfy 2^TAG_BITS >= TAGS.
- CPL_DW, 1024, completion buffer capacity in DW (1024..4096).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- cmd_ready, out, 1, command accept.
- cmd_valid, in, 1, command valid.
- cmd_addr, in, ADDR-2, DW address.
- cmd_len, in, LEN, length in DW.
- cmd_meta, in, META, metadata.
- cmd_last, in, 1, final piece of the original command.
- req_ready, in, 1, formatter accept.
- req_valid, out, 1, request valid.
- req_addr, out, ADDR-2, DW address.
- req_len, out, LEN, length in DW.
- req_tag, out, TAG_BITS, allocated tag.
- req_meta, out, META, metadata.
- req_last, out, 1, copy of cmd_last.
- cpl_valid, in, 1, completion report strobe.
- cpl_tag, in, TAG_BITS, tag of the completion.
- cpl_len, in, 11, DW received in this completion (1..1024).
- cpl_last, in, 1, final completion for the tag.
- cpl_err, out, 1, one-cycle pulse on an illegal completion report.
- outstanding, out, TAG_BITS+1, number of tags in use.
- idle, out, 1, no tags in use and req_valid low.

Behaviour:
- Reset (async assert, sync release):
  - req_valid=0, cpl_err=0, outstanding=0, idle=1.
  - All tags free, all per-tag remaining counts 0, credits=CPL_DW.
  - req_addr/len/tag/meta/last are 0.
- Command DW count: dw = (cmd_len==0) ? 1024 : cmd_len, computed at 11 bits.
- cmd_ready = (!req_valid || req_ready) && (any tag free) && (credits >= dw).
  - cmd_ready depends combinationally on cmd_len. The upstream splitter holds its command stable while valid, so this is legal.
- Accept (cmd_valid && cmd_ready), all effects visible on the next edge:
  - Allocate the lowest-numbered free tag (priority encode over the in-use bitmap, register-state only).
  - Mark that tag used; its remaining count = dw.
  - credits -= dw.
  - Register the req_* outputs from the cmd_* inputs plus the chosen tag; req_valid=1.
  - Latency: 1 cycle from accept to req_valid.
- Output handshake:
  - req_* stays stable while req_valid && !req_ready.
  - On req_ready with no new accept, req_valid clears.
  - Back-to-back accepts sustain one request per cycle.
- Completion report (cpl_valid), legal when:
  - the tag is in use, and
  - cpl_len <= remaining[tag], and
  - cpl_tag < TAGS.
- Legal report:
  - remaining[tag] -= cpl_len; credits += cpl_len.
  - If cpl_last: tag freed; any leftover remaining[tag] is also returned to credits (aborted or short completion); remaining[tag] = 0.
- Illegal report: no state change; cpl_err pulses high for exactly one cycle on the following edge.
- Simultaneous accept and completion in the same cycle:
  - credits_next = credits - dw + returned.
  - A tag freed this cycle is not visible to the allocator until the next cycle. The allocator never selects a tag whose free is pending.
  - Accept and completion on the same tag cannot occur, because an allocated tag is by definition not free.
- Credits never exceed CPL_DW and never go negative. Both are guaranteed by the legality rules; the verification engineer asserts them.
- outstanding is the registered population count of the in-use bitmap.
- idle = (outstanding==0) && !req_valid.
- rst_n asserted mid-transfer: all state is discarded immediately, including a req_valid held under backpressure. Completions arriving after reset for previously issued tags are flagged via cpl_err.

Test Plan:
- Reset then single command (cmd_len=32, addr=0x100) with req_ready=1 → req_valid one cycle later; req_tag=0, req_len=32; credits 1024→992; outstanding=1. Then cpl(tag 0, len 32, last) → credits 1024, outstanding 0, idle=1.
- Tag exhaustion (TAGS=8): issue 8 commands of len 16 with no completions → tags 0..7 issued in order, cmd_ready=0 on the 9th. cpl_last on tag 3 → the 9th command is accepted the cycle after and receives tag 3.
- Credit block: with CPL_DW=1024, issue len=0 (1024 DW) → accepted, credits 0. Next len=1 stalls. cpl(tag 0, len 512, !last) → credits 512 and the stalled command proceeds.
- Simultaneous events: accept len=64 in the same cycle as cpl(len 64, last) on another tag with credits=64 beforehand → credits stay 64; freed tag is not reused that cycle.
- Errors: cpl on a free tag, cpl_len=40 against remaining 32, and cpl_tag=9 with TAGS=8 → cpl_err single-cycle pulse each time; credits and outstanding unchanged.
- Backpressure/reset: hold req_ready=0 for 5 cycles → req_* stable and cmd_ready=0. Assert rst_n low mid-hold → req_valid drops asynchronously, credits=CPL_DW after release.
